// File: rtl/icache_dm_if.sv
// icache_dm_if: datapath fetch port, memory read port and performance counters of icache_dm
interface icache_dm_if #(parameter int CNT_W = 16);
   logic             imemREN;
   logic [31:0]      imemaddr;
   logic             inval;
   logic [31:0]      imemload;
   logic             ihit;
   logic             iREN;
   logic [31:0]      iaddr;
   logic [31:0]      iload;
   logic             iwait;
   logic [CNT_W-1:0] hit_count;
   logic [CNT_W-1:0] miss_count;
   modport slave (
      input  imemREN, imemaddr, inval, iload, iwait,
      output imemload, ihit, iREN, iaddr, hit_count, miss_count
   );
   modport master (
      output imemREN, imemaddr, inval, iload, iwait,
      input  imemload, ihit, iREN, iaddr, hit_count, miss_count
   );
endinterface

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped one-word-per-line read-only instruction cache
// with a two-state fill FSM and saturating hit/miss counters.
module icache_dm #(
   parameter int SETS  = 16,
   parameter int CNT_W = 16
) (
   input  logic      CLK,
   input  logic      RST,
   icache_dm_if.slave bus
);
   localparam int IDX = $clog2(SETS);
   localparam int TW  = 30 - IDX;
   typedef enum logic {IDLE, FILL} state_t;
   state_t           r_state;
   logic [SETS-1:0]  r_valid;
   logic [TW-1:0]    r_tag [SETS];
   logic [31:0]      r_data [SETS];
   logic [31:0]      r_fill_addr;
   logic [CNT_W-1:0] r_hit_cnt;
   logic [CNT_W-1:0] r_miss_cnt;
   logic [IDX-1:0]   w_idx;
   logic [IDX-1:0]   w_fidx;
   logic             w_hit;
   logic             w_miss;
   logic             w_done;
   always_comb begin
      w_idx  = bus.imemaddr[IDX+1:2];
      w_fidx = r_fill_addr[IDX+1:2];
      w_hit  = r_state == IDLE && bus.imemREN && r_valid[w_idx] && r_tag[w_idx] == bus.imemaddr[31:IDX+2];
      w_miss = r_state == IDLE && bus.imemREN && !w_hit;
      w_done = r_state == FILL && !bus.iwait;
   end
   assign bus.ihit       = w_hit;
   assign bus.imemload   = w_hit ? r_data[w_idx] : '0;
   assign bus.iREN       = r_state == FILL;
   assign bus.iaddr      = r_state == FILL ? r_fill_addr : '0;
   assign bus.hit_count  = r_hit_cnt;
   assign bus.miss_count = r_miss_cnt;
   // Invalidate is applied last so it wins over a fill completing on the same edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= IDLE;
         r_valid     <= '0;
         r_fill_addr <= '0;
         r_hit_cnt   <= '0;
         r_miss_cnt  <= '0;
      end else begin
         if (w_hit && r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
         if (w_miss) begin
            r_fill_addr <= {bus.imemaddr[31:2], 2'b00};
            r_state     <= FILL;
            if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
         end
         if (w_done) begin
            r_valid[w_fidx] <= 1'b1;
            r_state         <= IDLE;
         end
         if (bus.inval) r_valid <= '0;
      end
   end
   always_ff @(posedge CLK) begin
      if (w_done) begin
         r_tag[w_fidx]  <= r_fill_addr[31:IDX+2];
         r_data[w_fidx] <= bus.iload;
      end
   end
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed scenarios plus random traffic against a
// behavioural model of the cache (line arrays, fill flag, counters).
module tb_icache_dm;
   localparam int CMAX = 15;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_pass = 0;
   bit [15:0]   m_valid;
   logic [25:0] m_tag [16];
   logic [31:0] m_data [16];
   bit          m_fill;
   logic [31:0] m_faddr;
   int          m_hits;
   int          m_miss;
   icache_dm_if #(.CNT_W(4)) bus();
   icache_dm #(.SETS(16), .CNT_W(4)) dut (.CLK(clk), .RST(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else n_pass++;
   endtask
   task automatic cyc(bit r, bit ren, logic [31:0] a, bit inv, bit w, logic [31:0] ld);
      bit h;
      int ix;
      int fx;
      @(posedge clk);
      #1;
      rst = r;
      bus.imemREN = ren;
      bus.imemaddr = a;
      bus.inval = inv;
      bus.iwait = w;
      bus.iload = ld;
      #3;
      ix = int'(a[5:2]);
      h = !m_fill && ren && m_valid[ix] && m_tag[ix] == a[31:6];
      chk("ihit", {31'b0, bus.ihit}, {31'b0, h});
      chk("imemload", bus.imemload, h ? m_data[ix] : 32'h0);
      chk("iREN", {31'b0, bus.iREN}, {31'b0, m_fill});
      chk("iaddr", bus.iaddr, m_fill ? m_faddr : 32'h0);
      chk("hit_count", {28'b0, bus.hit_count}, m_hits);
      chk("miss_count", {28'b0, bus.miss_count}, m_miss);
      if (r) begin
         m_valid = '0; m_fill = 0; m_faddr = '0; m_hits = 0; m_miss = 0;
      end else begin
         if (h) m_hits = m_hits < CMAX ? m_hits + 1 : CMAX;
         if (!m_fill && ren && !h) begin
            m_fill = 1;
            m_faddr = {a[31:2], 2'b00};
            m_miss = m_miss < CMAX ? m_miss + 1 : CMAX;
         end else if (m_fill && !w) begin
            fx = int'(m_faddr[5:2]);
            m_valid[fx] = 1'b1;
            m_tag[fx] = m_faddr[31:6];
            m_data[fx] = ld;
            m_fill = 0;
         end
         if (inv) m_valid = '0;
      end
   endtask
   task automatic fill(logic [31:0] a, int waits, logic [31:0] ld);
      cyc(0, 1, a, 0, 0, 0);
      repeat (waits) cyc(0, 1, a, 0, 1, 0);
      cyc(0, 1, a, 0, 0, ld);
   endtask
   initial begin
      bus.imemREN = 0; bus.imemaddr = '0; bus.inval = 0; bus.iwait = 1; bus.iload = '0;
      m_valid = '0; m_fill = 0; m_faddr = '0; m_hits = 0; m_miss = 0;
      repeat (2) @(posedge clk);
      cyc(0, 0, 0, 0, 1, 0);
      chk("rst_iren", {31'b0, bus.iREN}, 0);
      // cold miss
      cyc(0, 1, 32'h40, 0, 1, 0);
      chk("t1_cold_ihit", {31'b0, bus.ihit}, 0);
      cyc(0, 1, 32'h40, 0, 1, 0);
      chk("t1_iren", {31'b0, bus.iREN}, 1);
      chk("t1_iaddr", bus.iaddr, 32'h40);
      repeat (2) cyc(0, 1, 32'h40, 0, 1, 0);
      cyc(0, 1, 32'h40, 0, 0, 32'h20010005);
      cyc(0, 1, 32'h40, 0, 1, 0);
      chk("t1_hit", {31'b0, bus.ihit}, 1);
      chk("t1_load", bus.imemload, 32'h20010005);
      chk("t1_miss", {28'b0, bus.miss_count}, 1);
      cyc(0, 1, 32'h40, 0, 1, 0);
      chk("t1_hitcnt", {28'b0, bus.hit_count}, 1);
      // conflict eviction on index 0
      fill(32'h80, 1, 32'h11110080);
      fill(32'h40, 1, 32'h20010005);
      chk("t2_miss", {28'b0, bus.miss_count}, 3);
      cyc(0, 1, 32'h40, 0, 1, 0);
      chk("t2_rehit", {31'b0, bus.ihit}, 1);
      // redirect while a fill is pending
      cyc(0, 1, 32'h100, 0, 1, 0);
      cyc(0, 1, 32'h200, 0, 1, 0);
      chk("t3_hold", bus.iaddr, 32'h100);
      cyc(0, 1, 32'h200, 0, 0, 32'h00000100);
      chk("t3_hold2", bus.iaddr, 32'h100);
      cyc(0, 1, 32'h100, 0, 1, 0);
      chk("t3_hit100", {31'b0, bus.ihit}, 1);
      fill(32'h200, 1, 32'h00000200);
      chk("t3_iaddr200", bus.iaddr, 32'h200);
      // invalidate racing a fill completion
      cyc(0, 1, 32'h40, 0, 1, 0);
      cyc(0, 1, 32'h40, 1, 0, 32'h55);
      cyc(0, 1, 32'h40, 0, 1, 0);
      chk("t4_nohit", {31'b0, bus.ihit}, 0);
      cyc(0, 1, 32'h40, 0, 0, 32'h55);
      chk("t4_iren", {31'b0, bus.iREN}, 1);
      chk("t4_miss", {28'b0, bus.miss_count}, 7);
      // reset in the middle of a fill
      cyc(0, 1, 32'h44, 0, 1, 0);
      cyc(0, 1, 32'h44, 0, 1, 0);
      cyc(1, 1, 32'h44, 0, 1, 0);
      cyc(0, 1, 32'h40, 0, 1, 0);
      chk("t5_iren", {31'b0, bus.iREN}, 0);
      chk("t5_iaddr", bus.iaddr, 0);
      chk("t5_ihit", {31'b0, bus.ihit}, 0);
      chk("t5_hits", {28'b0, bus.hit_count}, 0);
      chk("t5_miss", {28'b0, bus.miss_count}, 0);
      // hit counter saturation
      cyc(0, 1, 32'h40, 0, 0, 32'h66);
      repeat (20) cyc(0, 1, 32'h40, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 0);
      chk("t6_hitsat", {28'b0, bus.hit_count}, 15);
      chk("t6_miss", {28'b0, bus.miss_count}, 1);
      for (int i = 0; i < 3000; i++)
         cyc($urandom % 100 == 0, $urandom % 10 < 8, 32'($urandom_range(0, 255)),
             $urandom % 40 == 0, 1'($urandom % 2), $urandom);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
